// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Detects ecall/ebreak, external interrupts and mret in decode, then walks a
// short FSM that writes mepc/mstatus/mcause (or restores mstatus on mret)
// and finally issues a one-cycle redirect to mtvec or mepc.
module trap_ctrl #(
  parameter logic [31:0] ASYNC_CAUSE  = 32'h8000_0007,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_busy_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEPC    = 3'd1;
  localparam logic [2:0] S_MSTATUS = 3'd2;
  localparam logic [2:0] S_MCAUSE  = 3'd3;
  localparam logic [2:0] S_MRET    = 3'd4;
  localparam logic [2:0] S_JUMP    = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] cause;
  logic [31:0] saved_pc;
  logic        kind_mret;

  logic idle;
  logic is_ecall;
  logic is_ebreak;
  logic sync_ev;
  logic async_ev;
  logic mret_ev;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] ms);
    mstatus_trap = {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] ms);
    mstatus_mret = {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
  endfunction

  // Events are only decoded in IDLE; priority SYNC > ASYNC > MRET.
  assign idle      = (state == S_IDLE);
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign sync_ev   = idle & (is_ecall | is_ebreak);
  assign async_ev  = idle & ~sync_ev & (|int_flag_i) & global_int_en_i & ~div_busy_i;
  assign mret_ev   = idle & ~sync_ev & ~async_ev & (inst_i == INST_MRET);

  // Next-state logic: every non-IDLE state lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (sync_ev || async_ev) state_nxt = S_MEPC;
        else if (mret_ev)        state_nxt = S_MRET;
      end
      S_MEPC:    state_nxt = S_MSTATUS;
      S_MSTATUS: state_nxt = S_MCAUSE;
      S_MCAUSE:  state_nxt = S_JUMP;
      S_MRET:    state_nxt = S_JUMP;
      S_JUMP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Latch cause, return PC and event kind at the moment an event is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause     <= 32'd0;
      saved_pc  <= 32'd0;
      kind_mret <= 1'b0;
    end else if (sync_ev) begin
      cause     <= is_ecall ? 32'd11 : 32'd3;
      saved_pc  <= inst_addr_i;
      kind_mret <= 1'b0;
    end else if (async_ev) begin
      cause     <= ASYNC_CAUSE;
      saved_pc  <= jump_flag_i ? jump_addr_i : inst_addr_i;
      kind_mret <= 1'b0;
    end else if (mret_ev) begin
      kind_mret <= 1'b1;
    end
  end

  // Output decode; reset forces IDLE so writes/redirect drop immediately,
  // and the detect-cycle hold is gated by reset directly.
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = 32'd0;
    data_o       = 32'd0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    hold_flag_o  = rst & (~idle | sync_ev | async_ev | mret_ev);
    case (state)
      S_MEPC: begin
        we_o    = 1'b1;
        waddr_o = {20'd0, MEPC_ADDR};
        data_o  = saved_pc;
      end
      S_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = {20'd0, MSTATUS_ADDR};
        data_o  = mstatus_trap(csr_mstatus_i);
      end
      S_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = {20'd0, MCAUSE_ADDR};
        data_o  = cause;
      end
      S_MRET: begin
        we_o    = 1'b1;
        waddr_o = {20'd0, MSTATUS_ADDR};
        data_o  = mstatus_mret(csr_mstatus_i);
      end
      S_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = kind_mret ? csr_mepc_i : csr_mtvec_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed scenarios followed by random traffic,
// all checked against a schedule-of-actions reference model.
module tb_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ACAUSE = 32'h8000_0007;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_busy_i, global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .div_busy_i(div_busy_i), .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a queue of pending per-cycle actions.
  // 1: write mepc (val)  2: write mstatus on entry  3: write mcause (val)
  // 4: write mstatus on mret  5: redirect to mtvec  6: redirect to mepc
  typedef struct { int act; logic [31:0] val; } act_t;
  act_t sched[$];
  int          ev_kind;
  logic [31:0] ev_cause, ev_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] inst, input logic [31:0] addr,
                        input logic [7:0] irq, input logic mie, input logic busy,
                        input logic jf, input logic [31:0] ja);
    inst_i = inst; inst_addr_i = addr; int_flag_i = irq; global_int_en_i = mie;
    div_busy_i = busy; jump_flag_i = jf; jump_addr_i = ja;
  endtask

  // Let combinational outputs settle after the falling edge, then compare.
  task automatic settle();
    logic e_hold, e_we, e_ia;
    logic [31:0] e_wa, e_d, e_iaddr, ms;
    #1;
    ms = csr_mstatus_i;
    e_hold = 0; e_we = 0; e_ia = 0; e_wa = 0; e_d = 0; e_iaddr = 0;
    ev_kind = 0;
    if (sched.size() == 0) begin
      if (inst_i == ECALL || inst_i == EBREAK) begin
        ev_kind = 1; ev_cause = (inst_i == ECALL) ? 32'd11 : 32'd3; ev_pc = inst_addr_i;
      end else if (int_flag_i != 0 && global_int_en_i && !div_busy_i) begin
        ev_kind = 1; ev_cause = ACAUSE; ev_pc = jump_flag_i ? jump_addr_i : inst_addr_i;
      end else if (inst_i == MRET) begin
        ev_kind = 2;
      end
      e_hold = (ev_kind != 0);
    end else begin
      e_hold = 1;
      case (sched[0].act)
        1: begin e_we = 1; e_wa = 32'h341; e_d = sched[0].val; end
        2: begin e_we = 1; e_wa = 32'h300; e_d = (ms & ~32'h88) | ((ms & 32'h8) << 4); end
        3: begin e_we = 1; e_wa = 32'h342; e_d = sched[0].val; end
        4: begin e_we = 1; e_wa = 32'h300; e_d = (ms & ~32'h88) | ((ms & 32'h80) >> 4) | 32'h80; end
        5: begin e_ia = 1; e_iaddr = csr_mtvec_i; end
        default: begin e_ia = 1; e_iaddr = csr_mepc_i; end
      endcase
    end
    chk("hold", {31'd0, hold_flag_o}, {31'd0, e_hold});
    chk("we", {31'd0, we_o}, {31'd0, e_we});
    chk("waddr", waddr_o, e_wa);
    chk("data", data_o, e_d);
    chk("int_assert", {31'd0, int_assert_o}, {31'd0, e_ia});
    chk("int_addr", int_addr_o, e_iaddr);
  endtask

  task automatic adv();
    @(posedge clk);
    if (sched.size() != 0) void'(sched.pop_front());
    else if (ev_kind == 1) begin
      sched.push_back('{1, ev_pc});
      sched.push_back('{2, 32'd0});
      sched.push_back('{3, ev_cause});
      sched.push_back('{5, 32'd0});
    end else if (ev_kind == 2) begin
      sched.push_back('{4, 32'd0});
      sched.push_back('{6, 32'd0});
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hold"}, {31'd0, hold_flag_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, we_o}, 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
    chk({tag, "_int"}, {31'd0, int_assert_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(NOP, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    csr_mtvec_i = 32'h1000; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h8;
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // ecall at 0x100, mstatus 0x8; event taken in the first cycle after reset
    set_in(ECALL, 32'h100, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("ecall_detect_hold", {31'd0, hold_flag_o}, 32'd1);
    adv();
    set_in(NOP, 32'h104, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); chk("ecall_mepc", data_o, 32'h100); adv();
    settle(); chk("ecall_mstatus", data_o, 32'h80); adv();
    settle(); chk("ecall_mcause", data_o, 32'd11); adv();
    settle(); chk("ecall_jump", int_addr_o, 32'h1000); adv();
    settle(); chk("ecall_done_hold", {31'd0, hold_flag_o}, 32'd0); adv();

    // interrupt with redirect in flight
    set_in(NOP, 32'h180, 8'h01, 1'b1, 1'b0, 1'b1, 32'h200);
    settle(); adv();
    set_in(NOP, 32'h200, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
    settle(); chk("irq_mepc", data_o, 32'h200); adv();
    cyc();
    settle(); chk("irq_mcause", data_o, ACAUSE); adv();
    cyc(); cyc();

    // interrupt masked by MIE=0
    set_in(NOP, 32'h200, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cyc();

    // mret
    csr_mstatus_i = 32'h80;
    set_in(MRET, 32'h300, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    set_in(NOP, 32'h304, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); chk("mret_mstatus", data_o, 32'h88); adv();
    settle(); chk("mret_jump", int_addr_o, 32'h104); adv();
    cyc();

    // ebreak and interrupt in the same cycle; interrupt taken afterwards
    csr_mstatus_i = 32'h8;
    set_in(EBREAK, 32'h400, 8'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    set_in(NOP, 32'h404, 8'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(); cyc();
    settle(); chk("ebreak_cause", data_o, 32'd3); adv();
    cyc();
    cyc();
    set_in(NOP, 32'h404, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(); cyc();
    settle(); chk("late_irq_cause", data_o, ACAUSE); adv();
    cyc(); cyc();

    // interrupt deferred while the divider is busy
    set_in(NOP, 32'h500, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cyc();
    div_busy_i = 1'b0;
    settle(); adv();
    int_flag_i = 8'h0;
    repeat (5) cyc();

    // reset in the middle of trap entry
    set_in(ECALL, 32'h600, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    set_in(NOP, 32'h604, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle(); adv();
    settle();
    #1 rst = 1'b0;
    #1 chk_all_zero("midreset");
    sched.delete();
    @(negedge clk);
    chk_all_zero("midreset_hold");
    rst = 1'b1;
    repeat (5) cyc();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: inst_i = ECALL;
        1: inst_i = EBREAK;
        2: inst_i = MRET;
        default: inst_i = $urandom;
      endcase
      inst_addr_i = $urandom;
      int_flag_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      global_int_en_i = 1'($urandom);
      div_busy_i = ($urandom_range(0, 3) == 0);
      jump_flag_i = 1'($urandom);
      jump_addr_i = $urandom;
      csr_mtvec_i = $urandom;
      csr_mepc_i = $urandom;
      csr_mstatus_i = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
